// File: rtl/weight_pkg.sv
// Types and helpers shared by the weight loader and the weight memory.
package weight_pkg;

    localparam int DATA_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loader_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_index_counter.sv
// Four nested wrapping counters walking a [in][out][k_y][k_x] weight tensor,
// k_x fastest; `last` flags the final element.
module weight_index_counter
    import weight_pkg::*;
#(
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 1,
    parameter int DIM         = 1,
    localparam int IN_W  = idx_width(NUM_INPUTS),
    localparam int OUT_W = idx_width(NUM_OUTPUTS),
    localparam int K_W   = idx_width(DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [IN_W-1:0]  idx_in,
    output logic [OUT_W-1:0] idx_out,
    output logic [K_W-1:0]   idx_k_y,
    output logic [K_W-1:0]   idx_k_x,
    output logic             last
);

    localparam logic [IN_W-1:0]  IN_MAX  = IN_W'(NUM_INPUTS - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(NUM_OUTPUTS - 1);
    localparam logic [K_W-1:0]   K_MAX   = K_W'(DIM - 1);

    logic in_max, out_max, ky_max, kx_max;

    assign in_max  = (idx_in  == IN_MAX);
    assign out_max = (idx_out == OUT_MAX);
    assign ky_max  = (idx_k_y == K_MAX);
    assign kx_max  = (idx_k_x == K_MAX);
    assign last    = in_max & out_max & ky_max & kx_max;

    // NOTE: non-blocking assignments, so every level tests the pre-edge wrap flags.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idx_in  <= '0;
            idx_out <= '0;
            idx_k_y <= '0;
            idx_k_x <= '0;
        end else if (inc) begin
            if (kx_max) begin
                idx_k_x <= '0;
                if (ky_max) begin
                    idx_k_y <= '0;
                    if (out_max) begin
                        idx_out <= '0;
                        idx_in  <= in_max ? '0 : idx_in + 1'b1;
                    end else begin
                        idx_out <= idx_out + 1'b1;
                    end
                end else begin
                    idx_k_y <= idx_k_y + 1'b1;
                end
            end else begin
                idx_k_x <= idx_k_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Accepts a valid/ready weight stream after `start` and writes each beat into
// the weight memory at its tensor address; pulses `done` with the final write.
module weight_loader
    import weight_pkg::*;
#(
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 1,
    parameter int DIM         = 1,
    parameter int DATA_SIZE   = weight_pkg::DATA_SIZE,
    localparam int IN_W  = idx_width(NUM_INPUTS),
    localparam int OUT_W = idx_width(NUM_OUTPUTS),
    localparam int K_W   = idx_width(DIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 write,
    output logic [IN_W-1:0]      index_in,
    output logic [OUT_W-1:0]     index_out,
    output logic [K_W-1:0]       index_k_y,
    output logic [K_W-1:0]       index_k_x,
    output logic [DATA_SIZE-1:0] in_data,
    output logic                 busy,
    output logic                 done
);

    loader_state_t    state;
    logic             fire;
    logic             clear;
    logic             last;
    logic [IN_W-1:0]  cnt_in;
    logic [OUT_W-1:0] cnt_out;
    logic [K_W-1:0]   cnt_k_y;
    logic [K_W-1:0]   cnt_k_x;

    // Handshake decodes only the registered state, never s_valid.
    assign s_ready = (state == LOAD);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign fire    = s_valid && s_ready;
    assign clear   = (state == IDLE) && start;

    weight_index_counter #(
        .NUM_INPUTS (NUM_INPUTS),
        .NUM_OUTPUTS(NUM_OUTPUTS),
        .DIM        (DIM)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .inc    (fire),
        .idx_in (cnt_in),
        .idx_out(cnt_out),
        .idx_k_y(cnt_k_y),
        .idx_k_x(cnt_k_x),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            write     <= 1'b0;
            index_in  <= '0;
            index_out <= '0;
            index_k_y <= '0;
            index_k_x <= '0;
            in_data   <= '0;
        end else begin
            write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    if (fire) begin
                        write     <= 1'b1;
                        in_data   <= s_data;
                        index_in  <= cnt_in;
                        index_out <= cnt_out;
                        index_k_y <= cnt_k_y;
                        index_k_x <= cnt_k_x;
                        if (last) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench: a 2x2x3x3 loader checked through an expected-write queue,
// plus an all-ones instance for the single-beat case.
module tb_weight_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Large instance: NUM_INPUTS=2, NUM_OUTPUTS=2, DIM=3.
    logic        b_start, b_valid, b_ready, b_write, b_busy, b_done;
    logic [63:0] b_sdata, b_data;
    logic [0:0]  b_in, b_out;
    logic [1:0]  b_ky, b_kx;

    weight_loader #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .DIM(3), .DATA_SIZE(64)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .s_valid(b_valid), .s_ready(b_ready),
        .s_data(b_sdata), .write(b_write), .index_in(b_in), .index_out(b_out),
        .index_k_y(b_ky), .index_k_x(b_kx), .in_data(b_data), .busy(b_busy), .done(b_done)
    );

    // Degenerate instance: every dimension 1.
    logic        s_start, s_valid, s_ready, s_write, s_busy, s_done;
    logic [63:0] s_sdata, s_data;
    logic [0:0]  s_in, s_out, s_ky, s_kx;

    weight_loader #(.NUM_INPUTS(1), .NUM_OUTPUTS(1), .DIM(1), .DATA_SIZE(64)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_sdata), .write(s_write), .index_in(s_in), .index_out(s_out),
        .index_k_y(s_ky), .index_k_x(s_kx), .in_data(s_data), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        logic [0:0]  i;
        logic [0:0]  o;
        logic [1:0]  y;
        logic [1:0]  x;
        logic [63:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   writes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tensor address of beat number b, k_x fastest.
    task automatic push(input int b, input logic [63:0] d);
        exp_t e;
        e.i = 1'(b / 18);
        e.o = 1'((b / 9) % 2);
        e.y = 2'((b / 3) % 3);
        e.x = 2'(b % 3);
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (b_write === 1'b1) begin
            writes++;
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(b_write), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_in",   64'(b_in),  64'(e.i));
                check("wr_out",  64'(b_out), 64'(e.o));
                check("wr_k_y",  64'(b_ky),  64'(e.y));
                check("wr_k_x",  64'(b_kx),  64'(e.x));
                check("wr_data", b_data,     e.d);
            end
        end
    end

    initial begin
        int base;
        rst_n = 1'b0;
        b_start = 1'b0; b_valid = 1'b0; b_sdata = '0;
        s_start = 1'b0; s_valid = 1'b0; s_sdata = '0;

        // Reset state.
        tick(); tick();
        check("rst_ready", 64'(b_ready), 64'd0);
        check("rst_write", 64'(b_write), 64'd0);
        check("rst_busy",  64'(b_busy),  64'd0);
        check("rst_done",  64'(b_done),  64'd0);
        check("rst_idx",   64'({b_in, b_out, b_ky, b_kx}), 64'd0);
        check("rst_data",  b_data, 64'd0);
        rst_n = 1'b1;

        // Valid without start is never accepted.
        b_valid = 1'b1; b_sdata = 64'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", 64'(b_ready), 64'd0);
            check("idle_write", 64'(b_write), 64'd0);
        end
        b_valid = 1'b0;

        // Full back-to-back load, data = beat number.
        base = writes;
        b_start = 1'b1; tick(); b_start = 1'b0;
        check("load_ready", 64'(b_ready), 64'd1);
        check("load_busy",  64'(b_busy),  64'd1);
        for (int b = 0; b < 36; b++) begin
            b_valid = 1'b1; b_sdata = 64'(b);
            push(b, 64'(b));
            tick();
        end
        check("last_write", 64'(b_write), 64'd1);
        check("last_done",  64'(b_done),  64'd1);
        check("last_ready", 64'(b_ready), 64'd0);
        // 37th beat offered plus a start coinciding with DONE->IDLE.
        b_sdata = 64'hBAD; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("post_done",  64'(b_done),  64'd0);
        check("post_write", 64'(b_write), 64'd0);
        check("post_busy",  64'(b_busy),  64'd0);
        tick();
        check("start_at_done_ignored", 64'(b_ready), 64'd0);
        check("post_write2", 64'(b_write), 64'd0);
        b_valid = 1'b0;
        check("full_write_count", 64'(writes - base), 64'd36);

        // Stall pattern 1,0,0 for ten transfers, then reset mid-load.
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            b_valid = 1'b1; b_sdata = 64'h1000 + 64'(b);
            push(b, 64'h1000 + 64'(b));
            tick();
            check("stall_write_hi", 64'(b_write), 64'd1);
            b_valid = 1'b0;
            tick();
            check("stall_write_lo", 64'(b_write), 64'd0);
            tick();
            check("stall_write_lo2", 64'(b_write), 64'd0);
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("mid_rst_ready", 64'(b_ready), 64'd0);
        check("mid_rst_busy",  64'(b_busy),  64'd0);
        check("mid_rst_idx",   64'({b_in, b_out, b_ky, b_kx}), 64'd0);
        check("mid_rst_data",  b_data, 64'd0);
        check("mid_rst_queue", 64'(sb.size()), 64'd0);

        // Restart from zero; start during LOAD at beat 5 is ignored.
        base = writes;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int b = 0; b < 36; b++) begin
            b_valid = 1'b1; b_sdata = 64'h2000 + 64'(b);
            b_start = (b == 5);
            push(b, 64'h2000 + 64'(b));
            tick();
        end
        b_start = 1'b0;
        check("reload_done", 64'(b_done), 64'd1);
        b_valid = 1'b0;
        tick();
        check("reload_idle", 64'(b_busy), 64'd0);
        check("reload_write_count", 64'(writes - base), 64'd36);
        check("queue_drained", 64'(sb.size()), 64'd0);

        // Degenerate single-beat load.
        s_start = 1'b1; tick(); s_start = 1'b0;
        check("one_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b1; s_sdata = 64'h3FF0_0000_0000_0000;
        tick();
        check("one_write", 64'(s_write), 64'd1);
        check("one_done",  64'(s_done),  64'd1);
        check("one_idx",   64'({s_in, s_out, s_ky, s_kx}), 64'd0);
        check("one_data",  s_data, 64'h3FF0_0000_0000_0000);
        tick();
        check("one_idle_ready", 64'(s_ready), 64'd0);
        check("one_idle_write", 64'(s_write), 64'd0);
        check("one_idle_busy",  64'(s_busy),  64'd0);
        s_valid = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
